// File: rtl/mem_ctrl.sv
// mem_ctrl: memory-side end of the issue/memory interface. Queues issued load/store
// ops, presents the oldest one on an SRAM-like request/ack bus, tracks accepted
// requests until data_ok and returns tagged completions. Ops caught by a flush are
// carried to completion on the bus (protocol) but their responses are suppressed.
// Optional build macro: MEM_CTRL_PERF_EN adds perf_req_cnt / perf_wait_cnt.
module mem_ctrl #(
    parameter int unsigned QDEPTH       = 4,
    parameter int unsigned MAX_INFLIGHT = 2,
    parameter int unsigned PREG_W       = 6
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              flush,
    input  logic              mem_issued,
    input  logic              req_wr,
    input  logic [1:0]        req_size,
    input  logic [31:0]       req_addr,
    input  logic [31:0]       req_wdata,
    input  logic [PREG_W-1:0] req_preg,
    output logic              wait_mem,
    output logic              data_req,
    output logic              data_wr,
    output logic [1:0]        data_size,
    output logic [31:0]       data_addr,
    output logic [31:0]       data_wdata,
    input  logic              data_addr_ok,
    input  logic              data_data_ok,
    input  logic [31:0]       data_rdata,
    output logic              resp_valid,
    output logic              resp_wr,
    output logic [PREG_W-1:0] resp_preg,
    output logic [31:0]       resp_data
`ifdef MEM_CTRL_PERF_EN
    ,
    output logic [31:0]       perf_req_cnt,
    output logic [31:0]       perf_wait_cnt
`endif
);

    localparam int unsigned QW  = $clog2(QDEPTH);
    localparam int unsigned QCW = QW + 1;
    localparam int unsigned FW  = (MAX_INFLIGHT > 1) ? $clog2(MAX_INFLIGHT) : 1;

    // Request queue (payload storage is not reset; only pointers/count/kill are)
    logic              q_wr_q    [QDEPTH];
    logic [1:0]        q_size_q  [QDEPTH];
    logic [31:0]       q_addr_q  [QDEPTH];
    logic [31:0]       q_wdata_q [QDEPTH];
    logic [PREG_W-1:0] q_preg_q  [QDEPTH];
    logic [QDEPTH-1:0] q_kill_q;
    logic [QW-1:0]     q_head_q, q_head_d;
    logic [QW-1:0]     q_tail_q, q_tail_d;
    logic [QCW-1:0]    q_cnt_q, q_cnt_d;

    // In-flight FIFO: requests the bus accepted, awaiting data_ok
    logic [PREG_W-1:0]       f_preg_q [MAX_INFLIGHT];
    logic [MAX_INFLIGHT-1:0] f_wr_q;
    logic [MAX_INFLIGHT-1:0] f_vld_q, f_vld_d;
    logic [MAX_INFLIGHT-1:0] f_kill_q, f_kill_d;
    logic [FW-1:0]           f_head_q, f_head_d;
    logic [FW-1:0]           f_tail_q, f_tail_d;

    logic q_empty, q_full, f_empty, f_full;
    logic accept, retire, enq, keep_head;
    logic q_kill_d, any_kill_d, wait_d, wait_q;

    // In-flight depth need not be a power of two, so wrap explicitly
    function automatic logic [FW-1:0] f_inc(input logic [FW-1:0] p);
        return (p == FW'(MAX_INFLIGHT - 1)) ? '0 : p + FW'(1);
    endfunction

    // Bus handshake decode and next-state for queue, in-flight FIFO and wait_mem
    always_comb begin
        q_empty   = (q_cnt_q == '0);
        q_full    = (q_cnt_q == QCW'(QDEPTH));
        f_empty   = ~|f_vld_q;
        f_full    = &f_vld_q;
        data_req  = ~q_empty & ~f_full;
        accept    = data_req & data_addr_ok;
        retire    = data_data_ok & ~f_empty;
        enq       = mem_issued & ~flush & ~q_full;
        // The presented head must stay on the bus until accepted, even across a flush
        keep_head = flush & data_req & ~data_addr_ok;

        q_head_d = accept ? q_head_q + QW'(1) : q_head_q;
        if (flush) begin
            q_tail_d = q_head_d + QW'(keep_head);
            q_cnt_d  = QCW'(keep_head);
        end else begin
            q_tail_d = enq ? q_tail_q + QW'(1) : q_tail_q;
            q_cnt_d  = q_cnt_q + QCW'(enq) - QCW'(accept);
        end
        // Only the head entry can ever carry a kill mark
        q_kill_d = keep_head | (~flush & ~q_empty & ~accept & q_kill_q[q_head_q]);

        f_head_d = retire ? f_inc(f_head_q) : f_head_q;
        f_tail_d = accept ? f_inc(f_tail_q) : f_tail_q;
        f_vld_d  = f_vld_q;
        f_kill_d = flush ? '1 : f_kill_q;
        if (retire) begin
            f_vld_d[f_head_q] = 1'b0;
        end
        if (accept) begin
            f_vld_d[f_tail_q]  = 1'b1;
            f_kill_d[f_tail_q] = flush | q_kill_q[q_head_q];
        end

        any_kill_d = q_kill_d | (|(f_vld_d & f_kill_d));
        wait_d     = (q_cnt_d >= QCW'(QDEPTH - 1)) | any_kill_d;
    end

    assign wait_mem   = wait_q;
    assign data_wr    = data_req & q_wr_q[q_head_q];
    assign data_size  = data_req ? q_size_q[q_head_q]  : 2'b00;
    assign data_addr  = data_req ? q_addr_q[q_head_q]  : 32'h0;
    assign data_wdata = data_req ? q_wdata_q[q_head_q] : 32'h0;

    // State update: enqueue, accept into in-flight, retire into registered response
    always_ff @(posedge clk) begin
        if (!resetn) begin
            q_head_q   <= '0;
            q_tail_q   <= '0;
            q_cnt_q    <= '0;
            q_kill_q   <= '0;
            f_head_q   <= '0;
            f_tail_q   <= '0;
            f_vld_q    <= '0;
            f_kill_q   <= '0;
            wait_q     <= 1'b0;
            resp_valid <= 1'b0;
            resp_wr    <= 1'b0;
            resp_preg  <= '0;
            resp_data  <= 32'h0;
        end else begin
            if (enq) begin
                q_wr_q[q_tail_q]    <= req_wr;
                q_size_q[q_tail_q]  <= req_size;
                q_addr_q[q_tail_q]  <= req_addr;
                q_wdata_q[q_tail_q] <= req_wdata;
                q_preg_q[q_tail_q]  <= req_preg;
                q_kill_q[q_tail_q]  <= 1'b0;
            end
            if (keep_head) begin
                q_kill_q[q_head_q] <= 1'b1;
            end
            if (accept) begin
                f_wr_q[f_tail_q]   <= q_wr_q[q_head_q];
                f_preg_q[f_tail_q] <= q_preg_q[q_head_q];
            end
            q_head_q <= q_head_d;
            q_tail_q <= q_tail_d;
            q_cnt_q  <= q_cnt_d;
            f_head_q <= f_head_d;
            f_tail_q <= f_tail_d;
            f_vld_q  <= f_vld_d;
            f_kill_q <= f_kill_d;
            wait_q   <= wait_d;

            // A flush in the retire cycle kills the retiring entry as well
            resp_valid <= retire & ~f_kill_q[f_head_q] & ~flush;
            if (retire) begin
                resp_wr   <= f_wr_q[f_head_q];
                resp_preg <= f_preg_q[f_head_q];
                resp_data <= f_wr_q[f_head_q] ? 32'h0 : data_rdata;
            end
        end
    end

`ifdef MEM_CTRL_PERF_EN
    logic [31:0] perf_req_q;
    logic [31:0] perf_wait_q;

    // Count bus accepts and cycles spent throttling issue; both wrap naturally
    always_ff @(posedge clk) begin
        if (!resetn) begin
            perf_req_q  <= 32'h0;
            perf_wait_q <= 32'h0;
        end else begin
            if (accept) begin
                perf_req_q <= perf_req_q + 32'd1;
            end
            if (wait_q) begin
                perf_wait_q <= perf_wait_q + 32'd1;
            end
        end
    end

    assign perf_req_cnt  = perf_req_q;
    assign perf_wait_cnt = perf_wait_q;
`else
    // Performance counters not built
`endif

endmodule

// File: tb/tb_mem_ctrl.sv
// tb_mem_ctrl: directed scenarios plus a randomised bus-handshake run for mem_ctrl.
// Expected completions are queued when an op is issued and popped when resp_valid fires.
module tb_mem_ctrl;
    localparam int unsigned PREG_W = 6;

    logic              clk;
    logic              resetn;
    logic              flush;
    logic              mem_issued;
    logic              req_wr;
    logic [1:0]        req_size;
    logic [31:0]       req_addr;
    logic [31:0]       req_wdata;
    logic [PREG_W-1:0] req_preg;
    logic              wait_mem;
    logic              data_req;
    logic              data_wr;
    logic [1:0]        data_size;
    logic [31:0]       data_addr;
    logic [31:0]       data_wdata;
    logic              data_addr_ok;
    logic              data_data_ok;
    logic [31:0]       data_rdata;
    logic              resp_valid;
    logic              resp_wr;
    logic [PREG_W-1:0] resp_preg;
    logic [31:0]       resp_data;
`ifdef MEM_CTRL_PERF_EN
    logic [31:0]       perf_req_cnt;
    logic [31:0]       perf_wait_cnt;
    int                exp_req_cnt = 0;
    int                exp_wait_cnt = 0;
`endif

    int                n_checks = 0;
    int                n_errors = 0;
    logic [38:0]       exp_q[$];
    logic [31:0]       bus_q[$];
    logic [PREG_W-1:0] preg_ctr = '0;

    mem_ctrl #(
        .QDEPTH      (4),
        .MAX_INFLIGHT(2),
        .PREG_W      (PREG_W)
    ) u_dut (
        .clk          (clk),
        .resetn       (resetn),
        .flush        (flush),
        .mem_issued   (mem_issued),
        .req_wr       (req_wr),
        .req_size     (req_size),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .req_preg     (req_preg),
        .wait_mem     (wait_mem),
        .data_req     (data_req),
        .data_wr      (data_wr),
        .data_size    (data_size),
        .data_addr    (data_addr),
        .data_wdata   (data_wdata),
        .data_addr_ok (data_addr_ok),
        .data_data_ok (data_data_ok),
        .data_rdata   (data_rdata),
        .resp_valid   (resp_valid),
        .resp_wr      (resp_wr),
        .resp_preg    (resp_preg),
        .resp_data    (resp_data)
`ifdef MEM_CTRL_PERF_EN
        ,
        .perf_req_cnt (perf_req_cnt),
        .perf_wait_cnt(perf_wait_cnt)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, required $finish");
        $fatal(1);
    end

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h required 0x%0h", tag, act, exp);
        end
    endtask

    function automatic logic [31:0] mem_model(input logic [31:0] a);
        return {a[15:0], ~a[31:16]} ^ 32'h5A5A_0F0F;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        flush        = 1'b0;
        mem_issued   = 1'b0;
        req_wr       = 1'b0;
        req_size     = 2'd0;
        req_addr     = 32'h0;
        req_wdata    = 32'h0;
        req_preg     = '0;
        data_addr_ok = 1'b0;
        data_data_ok = 1'b0;
        data_rdata   = 32'h0;
    endtask

    // Drive one issue for the coming edge and record its expected completion
    task automatic issue(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [PREG_W-1:0] preg, input logic [31:0] rdata_exp);
        mem_issued = 1'b1;
        req_wr     = wr;
        req_size   = 2'd2;
        req_addr   = addr;
        req_wdata  = wdata;
        req_preg   = preg;
        exp_q.push_back({wr, preg, wr ? 32'h0 : rdata_exp});
    endtask

    // One cycle of randomised traffic with a memory model answering on the bus
    task automatic bus_cycle(input bit do_iss, input bit aok, input bit dok);
        logic [31:0] a;
        logic [31:0] addr;
        logic        wr;
        bit          acc;
        bit          ret;
        if (do_iss && !wait_mem) begin
            wr   = 1'($urandom_range(0, 1));
            addr = $urandom();
            issue(wr, addr, $urandom(), preg_ctr, mem_model(addr));
            preg_ctr = preg_ctr + 1'b1;
        end else begin
            mem_issued = 1'b0;
        end
        data_addr_ok = aok;
        data_data_ok = dok;
        data_rdata   = (bus_q.size() > 0) ? mem_model(bus_q[0]) : 32'h0;
        ret = dok && (bus_q.size() > 0);
        acc = aok && data_req;
        a   = data_addr;
        step();
        if (ret) void'(bus_q.pop_front());
        if (acc) bus_q.push_back(a);
    endtask

    // Scoreboard: every completion must match the oldest outstanding expectation
    always @(negedge clk) begin
        logic [38:0] e;
        if (resetn && resp_valid) begin
            if (exp_q.size() == 0) begin
                check_eq("resp_unexpected", 64'(resp_valid), 64'd0);
            end else begin
                e = exp_q.pop_front();
                check_eq("resp", 64'({resp_wr, resp_preg, resp_data}), 64'(e));
            end
        end
    end

`ifdef MEM_CTRL_PERF_EN
    always @(negedge clk) begin
        if (resetn) begin
            if (data_req && data_addr_ok) exp_req_cnt++;
            if (wait_mem) exp_wait_cnt++;
        end
    end
`endif

    initial begin
        idle_inputs();
        resetn = 1'b0;
        repeat (3) step();
        check_eq("rst_wait_mem", 64'(wait_mem), 64'd0);
        check_eq("rst_data_req", 64'(data_req), 64'd0);
        check_eq("rst_resp_valid", 64'(resp_valid), 64'd0);
        check_eq("rst_data_outs", 64'({data_wr, data_size, data_addr}), 64'd0);
        check_eq("rst_resp_outs", 64'({resp_wr, resp_preg, resp_data}), 64'd0);
        resetn = 1'b1;
        step();

        // Single load: addr_ok N+1, data_ok N+3, response N+4
        issue(1'b0, 32'h1000, 32'h0, 6'd5, 32'hDEAD_BEEF);
        step();
        mem_issued = 1'b0;
        check_eq("t1_req", 64'(data_req), 64'd1);
        check_eq("t1_addr", 64'(data_addr), 64'h1000);
        data_addr_ok = 1'b1;
        step();
        data_addr_ok = 1'b0;
        check_eq("t1_req_drop", 64'(data_req), 64'd0);
        step();
        data_data_ok = 1'b1;
        data_rdata   = 32'hDEAD_BEEF;
        check_eq("t1_no_resp_early", 64'(resp_valid), 64'd0);
        step();
        data_data_ok = 1'b0;
        check_eq("t1_resp_valid", 64'(resp_valid), 64'd1);
        step();
        check_eq("t1_resp_one_cycle", 64'(resp_valid), 64'd0);

        // Three back-to-back ops with the bus stalled, then drain against MAX_INFLIGHT
        issue(1'b0, 32'h2000, 32'h0, 6'd10, 32'h1111_1111);
        step();
        check_eq("t2_wait_1", 64'(wait_mem), 64'd0);
        issue(1'b1, 32'h2004, 32'hCAFE_0002, 6'd11, 32'h0);
        step();
        check_eq("t2_wait_2", 64'(wait_mem), 64'd0);
        issue(1'b0, 32'h2008, 32'h0, 6'd12, 32'h3333_3333);
        step();
        mem_issued = 1'b0;
        check_eq("t2_wait_full", 64'(wait_mem), 64'd1);
        check_eq("t2_req_held", 64'({data_req, data_wr, data_addr}), 64'({1'b1, 1'b0, 32'h2000}));
        step();
        check_eq("t2_req_stable", 64'({data_req, data_wr, data_addr}), 64'({1'b1, 1'b0, 32'h2000}));
        data_addr_ok = 1'b1;
        step();
        check_eq("t2_wait_clear", 64'(wait_mem), 64'd0);
        check_eq("t2_op2_payload", 64'({data_req, data_wr, data_wdata}),
                 64'({1'b1, 1'b1, 32'hCAFE_0002}));
        check_eq("t2_op2_addr", 64'(data_addr), 64'h2004);
        step();
        data_addr_ok = 1'b0;
        check_eq("t2_inflight_full", 64'(data_req), 64'd0);
        step();
        check_eq("t2_inflight_full2", 64'(data_req), 64'd0);
        data_data_ok = 1'b1;
        data_rdata   = 32'h1111_1111;
        step();
        data_data_ok = 1'b0;
        check_eq("t2_req_after_dok", 64'({data_req, data_addr}), 64'({1'b1, 32'h2008}));
        data_addr_ok = 1'b1;
        step();
        data_addr_ok = 1'b0;
        data_data_ok = 1'b1;
        data_rdata   = 32'h2222_2222;
        step();
        data_rdata   = 32'h3333_3333;
        step();
        data_data_ok = 1'b0;
        repeat (3) step();
        check_eq("t2_all_resp", 64'(exp_q.size()), 64'd0);

        // Flush with one in flight, head presented, one queued
        issue(1'b0, 32'h3000, 32'h0, 6'd20, 32'h0);
        step();
        issue(1'b1, 32'h3004, 32'h5555_0004, 6'd21, 32'h0);
        data_addr_ok = 1'b1;
        step();
        data_addr_ok = 1'b0;
        issue(1'b0, 32'h3008, 32'h0, 6'd22, 32'h0);
        step();
        check_eq("t4_presented", 64'({data_req, data_addr}), 64'({1'b1, 32'h3004}));
        issue(1'b0, 32'h300C, 32'h0, 6'd23, 32'h0);
        flush = 1'b1;
        exp_q.delete();
        step();
        flush      = 1'b0;
        mem_issued = 1'b0;
        check_eq("t4_wait_killed", 64'(wait_mem), 64'd1);
        check_eq("t4_head_kept", 64'({data_req, data_addr}), 64'({1'b1, 32'h3004}));
        data_addr_ok = 1'b1;
        step();
        data_addr_ok = 1'b0;
        check_eq("t4_queue_dropped", 64'(data_req), 64'd0);
        check_eq("t4_wait_inflight", 64'(wait_mem), 64'd1);
        data_data_ok = 1'b1;
        step();
        data_data_ok = 1'b0;
        check_eq("t4_no_resp_a", 64'(resp_valid), 64'd0);
        check_eq("t4_wait_one_left", 64'(wait_mem), 64'd1);
        step();
        data_data_ok = 1'b1;
        step();
        data_data_ok = 1'b0;
        check_eq("t4_no_resp_b", 64'(resp_valid), 64'd0);
        check_eq("t4_wait_released", 64'(wait_mem), 64'd0);
        step();

        // Enqueue + addr_ok + data_ok every cycle, then random handshakes, then drain
        for (int i = 0; i < 14; i++) bus_cycle(1'b1, 1'b1, 1'b1);
        for (int i = 0; i < 40; i++) begin
            bus_cycle($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)),
                      1'($urandom_range(0, 1)));
        end
        for (int k = 0; k < 60 && (exp_q.size() != 0 || bus_q.size() != 0); k++) begin
            bus_cycle(1'b0, 1'b1, 1'b1);
        end
        idle_inputs();
        repeat (2) step();
        check_eq("drain_resp", 64'(exp_q.size()), 64'd0);
        check_eq("drain_bus", 64'(bus_q.size()), 64'd0);
        check_eq("drain_idle", 64'({wait_mem, data_req}), 64'd0);

`ifdef MEM_CTRL_PERF_EN
        check_eq("perf_req", 64'(perf_req_cnt), 64'(exp_req_cnt));
        check_eq("perf_wait", 64'(perf_wait_cnt), 64'(exp_wait_cnt));
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
